// File: rtl/line_buf_pkg.sv
// Shared constants and helpers for the multi-row line buffer.
package line_buf_pkg;

  localparam int unsigned LB_DATA_W   = 32;
  localparam int unsigned LB_LINE_LEN = 76;
  localparam int unsigned LB_TAPS     = 2;

  typedef logic [LB_DATA_W-1:0] pixel_t;

  function automatic int unsigned col_width(input int unsigned line_len);
    return (line_len > 1) ? $clog2(line_len) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_taps_if.sv
// Pixel stream in, vertical tap window out.
interface line_buffer_taps_if
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W   = LB_DATA_W,
  parameter int unsigned LINE_LEN = LB_LINE_LEN,
  parameter int unsigned TAPS     = LB_TAPS
) ();

  localparam int unsigned COL_W = col_width(LINE_LEN);

  logic                   in_valid;
  logic                   in_sof;
  logic [DATA_W-1:0]      in_data;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_cur;
  logic [TAPS*DATA_W-1:0] out_taps;
  logic [COL_W-1:0]       out_col;
  logic                   window_full;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_cur, out_taps, out_col, window_full
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_cur, out_taps, out_col, window_full
  );

endinterface

// File: rtl/lb_line_ram.sv
// Single-port line RAM: asynchronous read of the old word, write on the clock edge.
module lb_line_ram #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LINE_LEN = 76,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LINE_LEN];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_buffer_taps.sv
// Multi-row line buffer presenting each pixel with the same column of the previous TAPS lines.
// Optional LINE_BUF_ZERO_FILL_EN zeroes taps that reach above the first line of the frame.
module line_buffer_taps
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W   = LB_DATA_W,
  parameter int unsigned LINE_LEN = LB_LINE_LEN,
  parameter int unsigned TAPS     = LB_TAPS
) (
  input logic               clk,
  input logic               rst_n,
  line_buffer_taps_if.slave bus
);

  localparam int unsigned COL_W  = col_width(LINE_LEN);
  localparam int unsigned ROWS_W = $clog2(TAPS + 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_LEN - 1);
  localparam logic [ROWS_W-1:0] FULL_ROWS = ROWS_W'(TAPS);

  logic [COL_W-1:0]       col_q, col_d, cur_col;
  logic [ROWS_W-1:0]      rows_q, rows_d, cur_rows;
  logic [DATA_W-1:0]      rd [TAPS];
  logic [TAPS*DATA_W-1:0] taps_d;

  logic                   out_valid_q;
  logic [DATA_W-1:0]      out_cur_q;
  logic [TAPS*DATA_W-1:0] out_taps_q;
  logic [COL_W-1:0]       out_col_q;
  logic                   window_full_q;

  // A start-of-frame pixel behaves as if the pointer and row count were already zero.
  always_comb begin
    cur_col  = bus.in_sof ? '0 : col_q;
    cur_rows = bus.in_sof ? '0 : rows_q;
    col_d    = col_q;
    rows_d   = rows_q;
    if (bus.in_valid) begin
      if (cur_col == LAST_COL) begin
        col_d  = '0;
        rows_d = (cur_rows == FULL_ROWS) ? cur_rows : cur_rows + 1'b1;
      end else begin
        col_d  = cur_col + 1'b1;
        rows_d = cur_rows;
      end
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic [DATA_W-1:0] wdata;

    // Each row shifts down one memory: memory k+1 takes what memory k held.
    if (k == 0) begin : g_first
      assign wdata = bus.in_data;
    end else begin : g_chain
      assign wdata = rd[k-1];
    end

    lb_line_ram #(
      .DATA_W  (DATA_W),
      .LINE_LEN(LINE_LEN),
      .ADDR_W  (COL_W)
    ) u_ram (
      .clk  (clk),
      .en   (bus.in_valid),
      .addr (cur_col),
      .wdata(wdata),
      .rdata(rd[k])
    );

`ifdef LINE_BUF_ZERO_FILL_EN
    assign taps_d[k*DATA_W +: DATA_W] = (cur_rows < ROWS_W'(k + 1)) ? '0 : rd[k];
`else
    assign taps_d[k*DATA_W +: DATA_W] = rd[k];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= '0;
      rows_q        <= '0;
      out_valid_q   <= 1'b0;
      out_cur_q     <= '0;
      out_taps_q    <= '0;
      out_col_q     <= '0;
      window_full_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      rows_q      <= rows_d;
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_cur_q     <= bus.in_data;
        out_taps_q    <= taps_d;
        out_col_q     <= cur_col;
        window_full_q <= (cur_rows == FULL_ROWS);
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_cur     = out_cur_q;
  assign bus.out_taps    = out_taps_q;
  assign bus.out_col     = out_col_q;
  assign bus.window_full = window_full_q;

endmodule

// File: doc/line_buffer_taps.md
# line_buffer_taps

Parametrised multi-row line buffer for the edge-detector pixel pipeline. It accepts one pixel per valid cycle and keeps a column pointer internally, so the caller no longer drives an address. Each accepted pixel is presented alongside the pixels from the same column on the previous TAPS lines. This produces the vertical window that feeds the Sobel/convolution stage, and replaces the fixed 76-deep, 32-bit, externally-addressed shift memory.

## Interface
- DATA_W, 32, pixel/word width in bits
- LINE_LEN, 76, pixels per line (≥2)
- TAPS, 2, number of delayed lines held (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel accepted this cycle
- in_sof  in  1  start of frame, qualified by in_valid; this pixel is column 0, line 0
- in_data  in  DATA_W  input pixel
- out_valid  out  1  registered; tap outputs valid this cycle
- out_cur  out  DATA_W  registered copy of the accepted pixel
- out_taps  out  TAPS*DATA_W  slice k-1 ([k*DATA_W-1:(k-1)*DATA_W]) is the same column, k lines earlier
- out_col  out  clog2(LINE_LEN)  column index of the presented pixel
- window_full  out  1  TAPS complete lines stored since the last frame start

## Operation
- Holds TAPS memories, each LINE_LEN × DATA_W, addressed by a shared column pointer col.
- On an in_valid cycle:
  - memory 1 reads its entry at col, then writes in_data there (read-before-write);
  - memory k>1 reads its entry at col, then writes memory k-1's read value there.
  - The read values register to out_taps, in_data to out_cur, col to out_col.
- col advances by 1 per accepted pixel and wraps from LINE_LEN-1 to 0.
- On wrap, line count rows increments, saturating at TAPS. window_full = (rows == TAPS).
- in_valid with in_sof forces this pixel to col 0 and rows 0; the next pointer becomes 1.
  - window_full drops in the following cycle.
  - Memory contents are not cleared.
- in_valid low is a stall:
  - col, rows, memories and tap data hold;
  - out_valid is 0 next cycle.
- in_sof without in_valid is ignored.
- Memory contents are not reset. Taps are undefined until filled, unless the macro below is defined.

## Timing
- Latency is 1 cycle: the pixel accepted at edge t appears on out_cur/out_taps/out_col with out_valid=1 after edge t.
- Tap k, at the output for pixel p, equals pixel p-k*LINE_LEN counted in accepted pixels since frame start, when that pixel exists.
- Throughput is one pixel per cycle, with no back-pressure.
- Reset values: out_valid=0, out_cur=0, out_taps=0, out_col=0, window_full=0, col=0, rows=0.
- Reset asserted mid-line abandons the line. The first accepted pixel after release is col 0.
- LINE_LEN not a power of 2: wrap is an explicit compare, never natural overflow.

## Configuration
- Macro: LINE_BUF_ZERO_FILL_EN.
- Defined: tap slice k outputs 0 whenever rows < k at the time the pixel is accepted. This gives a zero border on the first TAPS lines of every frame.
- Undefined: taps output raw memory contents. The consumer gates on window_full.

## Structure
- Package line_buf_pkg:
  - default constants: LB_DATA_W=32, LB_LINE_LEN=76, LB_TAPS=2;
  - typedef for the pixel word;
  - function computing the column pointer width.
- One sub-module, lb_line_ram: single-port LINE_LEN × DATA_W read-before-write RAM with en, addr, wdata, rdata.
  - Instantiated TAPS times in a generate loop.
  - No reset on the array.

## Test plan
Bench parameters are DATA_W=8, LINE_LEN=4, TAPS=2; pixels are an incrementing count starting at 1.

- Reset release, no in_valid for 5 cycles -> all outputs 0, out_valid 0.
- 12 consecutive pixels with sof on the first:
  - pixel 9 presented -> out_col=0, out_taps[7:0]=5, out_taps[15:8]=1;
  - window_full rises with pixel 9's output.
- Same stream with in_valid toggled every other cycle -> identical output sequence, out_valid only on the cycle after each accepted pixel.
- in_sof mid-line at the 6th pixel -> that pixel output with out_col=0, window_full=0; memories keep the previous data.
- With LINE_BUF_ZERO_FILL_EN: pixels 1–4 -> out_taps=0; pixels 5–8 -> slice 1 = 1..4, slice 2 = 0.
- rst_n pulsed low for one cycle after pixel 7 -> outputs 0 immediately; next accepted pixel has out_col=0, window_full=0.
